// File: rtl/hough_pkg.sv
// rtl/hough_pkg.sv - shared constants and state type for the UART frame receiver
package hough_pkg;

  localparam int IMG_WIDTH      = 1280;
  localparam int IMG_HEIGHT     = 720;
  localparam int PIXEL_BITS     = 24;
  localparam int MEM_DEPTH      = IMG_WIDTH * IMG_HEIGHT;
  localparam int ADDR_WIDTH     = $clog2(MEM_DEPTH);
  localparam int TIMEOUT_CYCLES = 25000;

  localparam logic [7:0] SYNC0 = 8'hAA;
  localparam logic [7:0] SYNC1 = 8'h55;

  typedef enum logic [1:0] {
    S_SYNC0 = 2'd0,
    S_SYNC1 = 2'd1,
    S_PIXEL = 2'd2
  } rx_state_t;

endpackage

// File: rtl/rx_watchdog.sv
// rtl/rx_watchdog.sv - idle-cycle counter with a one-cycle expire pulse at the terminal count
module rx_watchdog #(
  parameter  int TERMINAL_COUNT = 25000,
  localparam int CW             = $clog2(TERMINAL_COUNT + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // A clear in the same cycle as the threshold suppresses the expiry.
  assign expire_o = enable_i && !clear_i && (count_q == CW'(TERMINAL_COUNT - 1));

  always_comb begin
    count_d = count_q + CW'(1);
    if (clear_i || !enable_i || expire_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_frame_receiver.sv
// rtl/uart_frame_receiver.sv - sync-marker detect and B,G,R pixel assembly into frame-buffer writes
module uart_frame_receiver #(
  parameter  int IMG_WIDTH      = hough_pkg::IMG_WIDTH,
  parameter  int IMG_HEIGHT     = hough_pkg::IMG_HEIGHT,
  parameter  int TIMEOUT_CYCLES = hough_pkg::TIMEOUT_CYCLES,
  localparam int MEM_DEPTH      = IMG_WIDTH * IMG_HEIGHT,
  localparam int ADDR_WIDTH     = $clog2(MEM_DEPTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            rx_valid,
  input  logic [7:0]                      rx_byte,
  output logic                            fb_wr_en,
  output logic [ADDR_WIDTH-1:0]           fb_wr_addr,
  output logic [hough_pkg::PIXEL_BITS-1:0] fb_wr_data,
  output logic                            busy,
  output logic                            frame_done,
  output logic                            frame_error,
  output logic [ADDR_WIDTH-1:0]           pixel_count
);

  import hough_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  rx_state_t                  state_q, state_d;
  logic [1:0]                 phase_q, phase_d;
  logic [7:0]                 b_q, b_d;
  logic [7:0]                 g_q, g_d;
  logic                       fb_wr_en_q, fb_wr_en_d;
  logic [ADDR_WIDTH-1:0]      fb_wr_addr_q, fb_wr_addr_d;
  logic [PIXEL_BITS-1:0]      fb_wr_data_q, fb_wr_data_d;
  logic                       busy_q, busy_d;
  logic                       frame_done_q, frame_done_d;
  logic                       frame_error_q, frame_error_d;
  logic [ADDR_WIDTH-1:0]      pixel_count_q, pixel_count_d;
  logic                       expire;

  rx_watchdog #(
    .TERMINAL_COUNT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk),
    .rst_i    (reset),
    .clear_i  (rx_valid),
    .enable_i (state_q != S_SYNC0),
    .expire_o (expire)
  );

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    b_d           = b_q;
    g_d           = g_q;
    fb_wr_en_d    = 1'b0;
    fb_wr_addr_d  = fb_wr_addr_q;
    fb_wr_data_d  = fb_wr_data_q;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    pixel_count_d = pixel_count_q;
    busy_d        = (state_q != S_SYNC0);

    case (state_q)
      S_SYNC0: begin
        if (rx_valid && enable && (rx_byte == SYNC0)) begin
          state_d = S_SYNC1;
        end
      end

      S_SYNC1: begin
        if (rx_valid) begin
          if (rx_byte == SYNC1) begin
            state_d       = S_PIXEL;
            fb_wr_addr_d  = '0;
            pixel_count_d = '0;
            phase_d       = 2'd0;
          end else if (rx_byte != SYNC0) begin
            state_d = S_SYNC0;
          end
        end else if (expire) begin
          frame_error_d = 1'b1;
          state_d       = S_SYNC0;
          phase_d       = 2'd0;
        end
      end

      S_PIXEL: begin
        if (rx_valid) begin
          case (phase_q)
            2'd0: begin
              b_d     = rx_byte;
              phase_d = 2'd1;
            end
            2'd1: begin
              g_d     = rx_byte;
              phase_d = 2'd2;
            end
            default: begin
              // R completes the pixel straight from the bus, not from a holding register.
              fb_wr_en_d    = 1'b1;
              fb_wr_addr_d  = pixel_count_q;
              fb_wr_data_d  = {rx_byte, g_q, b_q};
              pixel_count_d = pixel_count_q + ADDR_WIDTH'(1);
              phase_d       = 2'd0;
              if (pixel_count_q == LAST_ADDR) begin
                frame_done_d = 1'b1;
                state_d      = S_SYNC0;
              end
            end
          endcase
        end else if (expire) begin
          frame_error_d = 1'b1;
          state_d       = S_SYNC0;
          phase_d       = 2'd0;
        end
      end

      default: begin
        state_d = S_SYNC0;
        phase_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_SYNC0;
      phase_q       <= 2'd0;
      b_q           <= '0;
      g_q           <= '0;
      fb_wr_en_q    <= 1'b0;
      fb_wr_addr_q  <= '0;
      fb_wr_data_q  <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      pixel_count_q <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      b_q           <= b_d;
      g_q           <= g_d;
      fb_wr_en_q    <= fb_wr_en_d;
      fb_wr_addr_q  <= fb_wr_addr_d;
      fb_wr_data_q  <= fb_wr_data_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      pixel_count_q <= pixel_count_d;
    end
  end

  assign fb_wr_en    = fb_wr_en_q;
  assign fb_wr_addr  = fb_wr_addr_q;
  assign fb_wr_data  = fb_wr_data_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign pixel_count = pixel_count_q;

endmodule

// File: tb/tb_uart_frame_receiver.sv
// tb/tb_uart_frame_receiver.sv - directed vector bench for uart_frame_receiver on a 4x2 image
module tb_uart_frame_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        fb_wr_en;
  logic [2:0]  fb_wr_addr;
  logic [23:0] fb_wr_data;
  logic        busy;
  logic        frame_done;
  logic        frame_error;
  logic [2:0]  pixel_count;

  int n_vec = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  uart_frame_receiver #(
    .IMG_WIDTH      (4),
    .IMG_HEIGHT     (2),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .fb_wr_en    (fb_wr_en),
    .fb_wr_addr  (fb_wr_addr),
    .fb_wr_data  (fb_wr_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_error (frame_error),
    .pixel_count (pixel_count)
  );

  always @(negedge clk) begin
    if (fb_wr_en)    wr_cnt++;
    if (frame_done)  done_cnt++;
    if (frame_error) err_cnt++;
  end

  typedef struct {
    logic        en;
    logic [7:0]  b;
    logic        wr;
    logic [2:0]  addr;
    logic [23:0] data;
    logic        done;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic [7:0] b, input logic wr,
                              input logic [2:0] addr, input logic [23:0] data,
                              input logic done, input logic bz);
    vec_t v;
    v.en = en; v.b = b; v.wr = wr; v.addr = addr; v.data = data; v.done = done; v.busy = bz;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic apply(input vec_t v, input int idx);
    enable = v.en;
    strobe(v.b);
    check($sformatf("v%0d_wr_en", idx), fb_wr_en, v.wr);
    if (v.wr) begin
      check($sformatf("v%0d_addr", idx), fb_wr_addr, v.addr);
      check($sformatf("v%0d_data", idx), fb_wr_data, v.data);
    end
    check($sformatf("v%0d_done", idx), frame_done, v.done);
    check($sformatf("v%0d_err", idx), frame_error, 1'b0);
    @(negedge clk);
    check($sformatf("v%0d_busy", idx), busy, v.busy);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] bb, gg, rr;
    int k;

    // gating: enable low, header and pixels ignored
    add(0, 8'hAA, 0, 0, 0, 0, 0);
    add(0, 8'h55, 0, 0, 0, 0, 0);
    add(0, 8'h01, 0, 0, 0, 0, 0);
    add(0, 8'h02, 0, 0, 0, 0, 0);
    add(0, 8'h03, 0, 0, 0, 0, 0);
    // nominal frame
    add(1, 8'hAA, 0, 0, 0, 0, 1);
    add(1, 8'h55, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      bb = 8'(i); gg = 8'(i + 16); rr = 8'(i + 32);
      add(1, bb, 0, 0, 0, 0, 1);
      add(1, gg, 0, 0, 0, 0, 1);
      add(1, rr, 1, 3'(i), {rr, gg, bb}, i == 7, i != 7);
    end
    // enable dropped after header; pixel 0 carries marker bytes as data
    add(1, 8'hAA, 0, 0, 0, 0, 1);
    add(1, 8'h55, 0, 0, 0, 0, 1);
    add(0, 8'hAA, 0, 0, 0, 0, 1);
    add(0, 8'h55, 0, 0, 0, 0, 1);
    add(0, 8'hAA, 1, 3'd0, 24'hAA55AA, 0, 1);
    for (int i = 1; i < 8; i++) begin
      bb = 8'(i + 8'h40); gg = 8'(i + 8'h50); rr = 8'(i + 8'h60);
      add(0, bb, 0, 0, 0, 0, 1);
      add(0, gg, 0, 0, 0, 0, 1);
      add(0, rr, 1, 3'(i), {rr, gg, bb}, i == 7, i != 7);
    end
    // sync hunting: 12 AA AA 55, then the start of a frame that will time out
    add(1, 8'h12, 0, 0, 0, 0, 0);
    add(1, 8'hAA, 0, 0, 0, 0, 1);
    add(1, 8'hAA, 0, 0, 0, 0, 1);
    add(1, 8'h55, 0, 0, 0, 0, 1);
    add(1, 8'h80, 0, 0, 0, 0, 1);
    add(1, 8'h90, 0, 0, 0, 0, 1);
    add(1, 8'hA0, 1, 3'd0, 24'hA09080, 0, 1);
    add(1, 8'h81, 0, 0, 0, 0, 1);
    add(1, 8'h91, 0, 0, 0, 0, 1);
    add(1, 8'hA1, 1, 3'd1, 24'hA19181, 0, 1);
    add(1, 8'h82, 0, 0, 0, 0, 1);
    add(1, 8'h92, 0, 0, 0, 0, 1);

    #3 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wr_en", fb_wr_en, 0);
    check("rst_addr", fb_wr_addr, 0);
    check("rst_data", fb_wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_err", frame_error, 0);
    check("rst_count", pixel_count, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) apply(vecs[i], i);
    check("frames_done", done_cnt, 2);

    // third pixel, then one lone byte exactly at the timeout threshold, then silence
    strobe(8'hA2);
    check("to_wr_en", fb_wr_en, 1);
    check("to_addr", fb_wr_addr, 2);
    check("to_data", fb_wr_data, 24'hA29282);
    repeat (98) @(negedge clk);
    strobe(8'h83);
    check("coincide_no_err", err_cnt, 0);
    k = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (frame_error) begin
        k = c;
        break;
      end
    end
    check("to_latency", k, 100);
    check("to_pixel_count", pixel_count, 3);
    check("to_no_done", done_cnt, 2);
    @(negedge clk);
    check("to_err_pulse", frame_error, 0);
    check("to_busy", busy, 0);
    check("to_err_cnt", err_cnt, 1);

    // restart after timeout lands at address 0
    strobe(8'hAA); idle();
    strobe(8'h55); idle();
    check("rs_count_clr", pixel_count, 0);
    strobe(8'h01); idle();
    strobe(8'h02); idle();
    strobe(8'h03);
    check("rs_addr0", fb_wr_addr, 0);
    check("rs_data0", fb_wr_data, 24'h030201);
    idle();
    strobe(8'h04); idle();
    strobe(8'h05); idle();
    strobe(8'h06);
    check("rs_addr1", fb_wr_addr, 1);
    idle();
    strobe(8'h07);
    @(negedge clk);

    // asynchronous reset between clock edges, mid-pixel
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("ar_addr", fb_wr_addr, 0);
    check("ar_data", fb_wr_data, 0);
    check("ar_busy", busy, 0);
    check("ar_count", pixel_count, 0);
    @(negedge clk);
    reset = 1'b0;
    idle();
    check("ar_no_done", done_cnt, 2);
    check("ar_no_err", err_cnt, 1);

    strobe(8'hAA); idle();
    strobe(8'h55); idle();
    strobe(8'h09); idle();
    strobe(8'h0A); idle();
    strobe(8'h0B);
    check("ar_wr_en", fb_wr_en, 1);
    check("ar_addr0", fb_wr_addr, 0);
    check("ar_data0", fb_wr_data, 24'h0B0A09);
    idle();
    check("total_writes", wr_cnt, 22);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_receiver.md
Name: uart_frame_receiver

Overview:
Upstream stage between the UART receiver and the 24-bit frame buffer. It detects a two-byte frame-start marker and assembles the following B,G,R byte triplets into 24-bit pixels. Each pixel is written to sequential frame-buffer addresses. At frame end it signals completion to the top-level FSM; if the byte stream stalls mid-frame it aborts with an error pulse.

Parameters:
IMG_WIDTH, 1280, pixels per line
IMG_HEIGHT, 720, lines per frame
PIXEL_BITS, 24, frame-buffer word width (fixed 3 bytes)
SYNC0, 8'hAA, first frame-start marker byte
SYNC1, 8'h55, second frame-start marker byte
TIMEOUT_CYCLES, 25000, idle clocks after the last byte before a mid-frame abort (1 ms at 25 MHz)
(derived localparams: MEM_DEPTH = IMG_WIDTH*IMG_HEIGHT; ADDR_WIDTH = $clog2(MEM_DEPTH))

Ports:
clk  in  1  system clock, 25 MHz
reset  in  1  asynchronous, active-high reset
enable  in  1  high = a new frame may start; sampled only in S_SYNC0
rx_valid  in  1  one-cycle strobe, rx_byte valid
rx_byte  in  8  received UART byte
fb_wr_en  out  1  one-cycle frame-buffer write strobe
fb_wr_addr  out  ADDR_WIDTH  write address
fb_wr_data  out  24  pixel {R,G,B}
busy  out  1  high in S_SYNC1 and S_PIXEL
frame_done  out  1  one-cycle pulse, frame fully written
frame_error  out  1  one-cycle pulse, frame aborted by timeout
pixel_count  out  ADDR_WIDTH  pixels written in the current frame

Behaviour:
- Reset (async assert, sync release): state=S_SYNC0; all outputs 0; byte phase=0; timeout counter=0.
- All outputs are registered. fb_wr_en, frame_done and frame_error are single-cycle pulses.
- S_SYNC0: bytes are ignored unless enable=1. On rx_byte==SYNC0 -> S_SYNC1; any other byte -> stay.
- S_SYNC1:
  - rx_byte==SYNC1 -> S_PIXEL; fb_wr_addr=0, pixel_count=0, byte phase=0.
  - rx_byte==SYNC0 -> stay in S_SYNC1.
  - any other byte -> S_SYNC0.
- S_PIXEL:
  - Phase 0 latches B; phase 1 latches G.
  - Phase 2: on the clock edge that samples rx_valid with the R byte, register fb_wr_data={rx_byte,G,B} and fb_wr_addr=current address, and assert fb_wr_en for the next cycle (1-cycle latency from the R strobe). The write always uses the current byte, never a stale assembler value.
  - After each write, address and pixel_count increment by 1.
  - Marker values have no special meaning inside S_PIXEL; they are treated as pixel data.
- Frame end: the write to address MEM_DEPTH-1 asserts frame_done in the same cycle as its fb_wr_en; state -> S_SYNC0. fb_wr_addr never exceeds MEM_DEPTH-1 (no wrap).
- Timeout:
  - Counter clears on every rx_valid and increments each clock in S_SYNC1/S_PIXEL.
  - On reaching TIMEOUT_CYCLES: frame_error pulses, state -> S_SYNC0, byte phase clears, pixel_count holds its value until the next SYNC1 acceptance.
  - Partial data already written stays in memory; no rollback.
  - If rx_valid and the timeout threshold coincide, the byte wins and no error is raised.
- enable dropping during S_SYNC1/S_PIXEL has no effect; the frame runs to completion or timeout.
- Reset mid-frame: immediate return to the reset state; no frame_done or frame_error is emitted.
- rx_valid pulses are at least 1 clock apart; back-to-back strobes on consecutive cycles must still be handled correctly.

Decomposition:
- Shared package hough_pkg: IMG_WIDTH, IMG_HEIGHT, PIXEL_BITS, MEM_DEPTH, ADDR_WIDTH, SYNC0/SYNC1, and typedef rx_state_t {S_SYNC0, S_SYNC1, S_PIXEL}.
- One sub-module is natural: rx_watchdog (clear/enable inputs, parameterised terminal count, one-cycle expire pulse).

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=2, TIMEOUT_CYCLES=100, bytes spaced 5 clocks):
- Nominal frame: enable=1; send AA 55, then 8 triplets B=i, G=i+0x10, R=i+0x20 for i=0..7 -> 8 writes, addr 0..7, data {i+0x20,i+0x10,i}; frame_done exactly with the addr-7 write; busy falls the next cycle.
- Sync hunting: send 12 AA AA 55 then a frame -> first pixel lands at addr 0; stray bytes cause no writes.
- Gating: enable=0; send AA 55 plus pixels -> no writes, busy stays 0. Enable dropped after the header -> frame still completes.
- Timeout: send header plus 10 bytes (3 pixels + 1 byte), then silence -> frame_error 100 clocks after the last byte; pixel_count=3; no frame_done. Next AA 55 restarts at addr 0.
- Marker in data: pixel bytes AA 55 AA -> written as data 0xAA55AA; no resync.
- Async reset asserted mid-pixel, between clock edges -> outputs 0 immediately; next header starts at addr 0.
